// File: rtl/knn_vote_pkg.sv
// Shared definitions for the KNN majority-vote stage: parameter defaults,
// FSM state encoding and the vote-counter width helper.
package knn_vote_pkg;

  localparam int KNN_HW_K_DEF    = 10;
  localparam int KNN_N_CLASS_DEF = 10;
  localparam int KNN_LABEL_W_DEF = 8;

  typedef enum logic [1:0] {
    KNN_VOTE_IDLE  = 2'd0,
    KNN_VOTE_ISSUE = 2'd1,
    KNN_VOTE_DRAIN = 2'd2,
    KNN_VOTE_DONE  = 2'd3
  } knn_state_e;

  // A counter must hold every value from 0 to HW_K inclusive.
  function automatic int knn_cnt_w(input int hw_k);
    return $clog2(hw_k + 1);
  endfunction

endpackage

// File: rtl/knn_class_counter.sv
// Per-class vote counters with a running argmax. best_o/best_cnt_o/oor_o
// already include the label accepted this cycle, so they can be captured on the same edge.
module knn_class_counter
  import knn_vote_pkg::*;
#(
  parameter int N_CLASS = KNN_N_CLASS_DEF,
  parameter int LABEL_W = KNN_LABEL_W_DEF,
  parameter int CNT_W   = knn_cnt_w(KNN_HW_K_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [LABEL_W-1:0] label_i,
  output logic [LABEL_W-1:0] best_o,
  output logic [CNT_W-1:0]   best_cnt_o,
  output logic               oor_o
);

  logic [CNT_W-1:0]   cnt_q [N_CLASS];
  logic [LABEL_W-1:0] best_q, best_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic               oor_q, oor_d;
  logic [CNT_W-1:0]   cur_cnt;
  logic [CNT_W-1:0]   new_cnt;
  logic               lbl_valid;

  always_comb begin
    cur_cnt = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      if (label_i == LABEL_W'(c)) cur_cnt = cnt_q[c];
    end
    lbl_valid = (label_i < LABEL_W'(N_CLASS));
    new_cnt   = cur_cnt + CNT_W'(1);

    best_d = best_q;
    bcnt_d = bcnt_q;
    oor_d  = oor_q;
    if (clr_i) begin
      best_d = '0;
      bcnt_d = '0;
      oor_d  = 1'b0;
    end else if (en_i) begin
      // Strict '>' keeps the class that reached a tied count first.
      if (lbl_valid && (new_cnt > bcnt_q)) begin
        best_d = label_i;
        bcnt_d = new_cnt;
      end
      if (!lbl_valid) oor_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int c = 0; c < N_CLASS; c++) cnt_q[c] <= '0;
      best_q <= '0;
      bcnt_q <= '0;
      oor_q  <= 1'b0;
    end else begin
      best_q <= best_d;
      bcnt_q <= bcnt_d;
      oor_q  <= oor_d;
      if (en_i && lbl_valid) begin
        for (int c = 0; c < N_CLASS; c++) begin
          if (label_i == LABEL_W'(c)) cnt_q[c] <= new_cnt;
        end
      end
    end
  end

  assign best_o     = best_d;
  assign best_cnt_o = bcnt_d;
  assign oor_o      = oor_d;

endmodule

// File: rtl/knn_vote.sv
// Majority-vote stage behind the KNN sorter: walks the sorted neighbours via sel_o,
// counts labels arriving one cycle later and reports winner, vote count and error flag.
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int HW_K    = KNN_HW_K_DEF,
  parameter int N_CLASS = KNN_N_CLASS_DEF,
  parameter int LABEL_W = KNN_LABEL_W_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [$clog2(HW_K+1)-1:0]                 k_i,
  output logic [((HW_K > 1) ? $clog2(HW_K) : 1)-1:0] sel_o,
  input  logic [LABEL_W-1:0]                        label_i,
  output logic                                      busy,
  output logic                                      done,
  output logic [LABEL_W-1:0]                        class_o,
  output logic [$clog2(HW_K+1)-1:0]                 votes_o,
  output logic                                      err
);

  localparam int CNT_W = knn_cnt_w(HW_K);
  localparam int SEL_W = (HW_K > 1) ? $clog2(HW_K) : 1;

  knn_state_e         state_q, state_d;
  logic [CNT_W-1:0]   keff_q;
  logic [SEL_W-1:0]   sel_q;
  logic               acc_en_q;
  logic [LABEL_W-1:0] class_q;
  logic [CNT_W-1:0]   votes_q;
  logic               err_q;

  logic               clr;
  logic               issue;
  logic               last_issue;
  logic               load;
  logic [LABEL_W-1:0] best;
  logic [CNT_W-1:0]   best_cnt;
  logic               oor;

  function automatic logic [CNT_W-1:0] clamp_k(input logic [CNT_W-1:0] k);
    return (k > CNT_W'(HW_K)) ? CNT_W'(HW_K) : k;
  endfunction

  assign last_issue = ((CNT_W'(sel_q) + CNT_W'(1)) == keff_q);

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    issue   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      KNN_VOTE_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = (clamp_k(k_i) != '0) ? KNN_VOTE_ISSUE : KNN_VOTE_DRAIN;
        end
      end
      KNN_VOTE_ISSUE: begin
        issue = 1'b1;
        if (last_issue) state_d = KNN_VOTE_DRAIN;
      end
      KNN_VOTE_DRAIN: begin
        load    = 1'b1;
        state_d = KNN_VOTE_DONE;
      end
      KNN_VOTE_DONE: begin
        state_d = KNN_VOTE_IDLE;
      end
      default: state_d = KNN_VOTE_IDLE;
    endcase
  end

  // Issue stage: sel_q addresses the sorter, acc_en_q marks the cycle its label returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= KNN_VOTE_IDLE;
      keff_q   <= '0;
      sel_q    <= '0;
      acc_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_en_q <= issue;
      if (clr) begin
        keff_q <= clamp_k(k_i);
        sel_q  <= '0;
      end else if (issue && !last_issue) begin
        sel_q <= sel_q + SEL_W'(1);
      end else if (load) begin
        sel_q <= '0;
      end
    end
  end

  knn_class_counter #(
    .N_CLASS (N_CLASS),
    .LABEL_W (LABEL_W),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .en_i       (acc_en_q),
    .label_i    (label_i),
    .best_o     (best),
    .best_cnt_o (best_cnt),
    .oor_o      (oor)
  );

  // Result stage: captured on the DRAIN edge so it is visible together with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      class_q <= '0;
      votes_q <= '0;
      err_q   <= 1'b0;
    end else if (clr) begin
      err_q <= 1'b0;
    end else if (load) begin
      class_q <= best;
      votes_q <= best_cnt;
      err_q   <= oor;
    end
  end

  assign sel_o   = sel_q;
  assign busy    = (state_q != KNN_VOTE_IDLE);
  assign done    = (state_q == KNN_VOTE_DONE);
  assign class_o = class_q;
  assign votes_o = votes_q;
  assign err     = err_q;

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote: a table of votes with hand-computed winners,
// plus reset, start-while-busy and reset-mid-vote sequences.
module tb_knn_vote;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] k_i;
  logic [3:0] sel_o;
  logic [7:0] label_i;
  logic       busy;
  logic       done;
  logic [7:0] class_o;
  logic [3:0] votes_o;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  typedef struct {
    int k;
    int lab [10];
    int cls;
    int votes;
    int err;
    int cyc;
    int glitch;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  // Sorter model: DATA_OUT follows SEL with one cycle of latency.
  always @(posedge clk) label_i <= mem[sel_o];

  knn_vote #(.HW_K(10), .N_CLASS(10), .LABEL_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k_i     (k_i),
    .sel_o   (sel_o),
    .label_i (label_i),
    .busy    (busy),
    .done    (done),
    .class_o (class_o),
    .votes_o (votes_o),
    .err     (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_vote(input string name, input vec_t v);
    int  keff;
    bit  seen;
    bit  sel_ok;
    for (int i = 0; i < 10; i++) mem[i] = 8'(v.lab[i]);
    for (int i = 10; i < 16; i++) mem[i] = 8'd2;
    keff   = (v.k > 10) ? 10 : v.k;
    seen   = 1'b0;
    sel_ok = 1'b1;
    start  = 1'b1;
    k_i    = 4'(v.k);
    for (int cyc = 1; cyc <= 30 && !seen; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == v.glitch) begin
        start = 1'b1;
        k_i   = 4'd2;
      end
      if (cyc == 1) check({name, " busy_c1"}, int'(busy), 1);
      if (cyc <= keff && sel_o != 4'(cyc - 1)) sel_ok = 1'b0;
      if (keff == 0 && sel_o != 4'd0) sel_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        check({name, " done_cycle"}, cyc, v.cyc);
        check({name, " class"}, int'(class_o), v.cls);
        check({name, " votes"}, int'(votes_o), v.votes);
        check({name, " err"}, int'(err), v.err);
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, int'(seen), 1);
    check({name, " sel_seq"}, int'(sel_ok), 1);
    tick();
    check({name, " done_pulse"}, int'(done), 0);
    check({name, " idle_busy"}, int'(busy), 0);
    check({name, " held_class"}, int'(class_o), v.cls);
    check({name, " held_err"}, int'(err), v.err);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    rst   = 1'b1;
    start = 1'b0;
    k_i   = 4'd0;

    vecs[0] = '{10, '{3,3,5,5,5,3,1,1,1,1}, 1, 4, 0, 12, 4};
    vecs[1] = '{4,  '{2,7,7,2,0,0,0,0,0,0}, 7, 2, 0, 6,  0};
    vecs[2] = '{0,  '{9,9,9,9,9,9,9,9,9,9}, 0, 0, 0, 2,  0};
    vecs[3] = '{15, '{0,9,9,0,0,9,2,2,2,2}, 2, 4, 0, 12, 0};
    vecs[4] = '{3,  '{12,4,12,0,0,0,0,0,0,0}, 4, 1, 1, 5, 0};
    vecs[5] = '{3,  '{5,9,5,0,0,0,0,0,0,0}, 5, 2, 0, 5,  0};
    vecs[6] = '{2,  '{6,6,0,0,0,0,0,0,0,0}, 6, 2, 0, 4,  0};

    // Reset for two cycles, then 20 quiet idle cycles.
    tick();
    tick();
    rst = 1'b0;
    check("rst sel", int'(sel_o), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst class", int'(class_o), 0);
    check("rst votes", int'(votes_o), 0);
    check("rst err", int'(err), 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy || class_o != 8'd0 || votes_o != 4'd0 || err) bad++;
    end
    check("rst idle20", bad, 0);

    for (int i = 0; i < 6; i++) run_vote($sformatf("v%0d", i), vecs[i]);

    // Abort: start re-pulsed at cycle 4 (ignored), reset at cycle 5.
    for (int i = 0; i < 10; i++) mem[i] = 8'(vecs[0].lab[i]);
    start = 1'b1;
    k_i   = 4'd10;
    tick();
    start = 1'b0;
    check("abort busy_c1", int'(busy), 1);
    tick();
    tick();
    tick();
    start = 1'b1;
    k_i   = 4'd2;
    tick();
    start = 1'b0;
    check("abort busy_c5", int'(busy), 1);
    check("abort sel_c5", int'(sel_o), 4);
    rst = 1'b1;
    tick();
    check("abort idle", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort class", int'(class_o), 0);
    check("abort votes", int'(votes_o), 0);
    check("abort sel", int'(sel_o), 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done || busy) bad++;
    end
    check("abort quiet", bad, 0);

    run_vote("restart", vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote classifier stage directly downstream of `pipeline_sorter` in the KNN accelerator. After the sorter holds the K nearest neighbours, this block walks the sorted list, nearest first, by driving the sorter's `SEL` and reading the neighbour label from `DATA_OUT`. It counts votes per class and produces the winning class, its vote count and an error flag for software.

## Interface

Parameters:

- `HW_K`, 10: neighbour slots in the sorter.
- `N_CLASS`, 10: number of valid classes. Labels 0..N_CLASS-1 are valid.
- `LABEL_W`, 8: label width, equal to the label field of `DATA_OUT`.

Ports:

- `clk` in, 1: clock. This is the only clock.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: begin a vote. Sampled only in IDLE.
- `k_i` in, clog2(HW_K+1): number of neighbours to use. Latched at start and clamped to HW_K.
- `sel_o` out, clog2(HW_K): neighbour index driven to the sorter `SEL`.
- `label_i` in, LABEL_W: label of neighbour `sel_o`, valid 1 cycle after `sel_o`.
- `busy` out, 1: high from the cycle after start through the DONE cycle.
- `done` out, 1: single-cycle pulse when the result updates.
- `class_o` out, LABEL_W: winning class.
- `votes_o` out, clog2(HW_K+1): vote count of the winner.
- `err` out, 1: an out-of-range label was seen in the last vote.

## Operation

FSM states are IDLE, ISSUE, DRAIN and DONE.

- **IDLE + start:**
  - Latch `keff = min(k_i, HW_K)`.
  - Clear all N_CLASS counters, best-class/best-count and `err`.
  - Go to ISSUE if keff>0, else go to DRAIN.
- **ISSUE:**
  - Drive `sel_o = i` for i = 0..keff-1, one per cycle.
  - Set a one-stage `acc_en` pipeline flag alongside each issue.
  - After issuing keff-1, go to DRAIN.
- **Accumulate** (any cycle with `acc_en` delayed by 1):
  - If `label_i < N_CLASS`, increment `cnt[label_i]` and compute `new = cnt[label_i]+1`.
  - If `new > best_cnt`, set `best = label_i` and `best_cnt = new`.
  - If `label_i >= N_CLASS`, do not count it and set `err`.
- **DRAIN:** completes the final accumulate, then always goes to DONE.
- **DONE:** register `class_o = best` and `votes_o = best_cnt`, pulse `done`, return to IDLE.
- **Tie rule:** the winner is the class with the highest final count. Among tied classes, the one that reached that count at the lowest neighbour index wins. This follows from the strict `>` update.
- **No valid votes:** if no valid label was counted, `class_o=0` and `votes_o=0`.
- **Start while busy:** ignored.
- **Counter widths:** counters are clog2(HW_K+1) bits and never overflow, because keff ≤ HW_K.
- **Held outputs:** `class_o`, `votes_o` and `err` hold until the next DONE or reset. `err` clears at start.
- **Reset:**
  - Reset values: state IDLE, `sel_o=0`, `busy=0`, `done=0`, `class_o=0`, `votes_o=0`, `err=0`, counters 0.
  - Reset mid-vote abandons the vote. `class_o` does not update and `done` is not pulsed.

## Timing

- Cycle 0: `start` sampled in IDLE.
- Cycles 1..keff: ISSUE, with `sel_o = cycle-1`.
- Label for index i is sampled at the end of cycle i+2. The sorter read latency is 1 cycle.
- Cycle keff+1: DRAIN.
- Cycle keff+2: `done=1`, with new `class_o`/`votes_o` visible in the same cycle.
- Total latency is keff+2 cycles. For HW_K=10 that is done at cycle 12; keff=0 gives done at cycle 2.
- Next start is accepted from cycle keff+3.
- `sel_o` is registered. `label_i` must be stable for the whole sample cycle.

## Structure

- **Shared header `iob_knn.vh`:**
  - Defaults for `HW_K`, `N_CLASS`, `LABEL_W`.
  - FSM state encodings (`KNN_VOTE_IDLE`, `_ISSUE`, `_DRAIN`, `_DONE`).
  - Width macros (`KNN_CNT_W = clog2(HW_K+1)`).
- **Sub-module `knn_class_counter`:** N_CLASS counters plus running argmax. Inputs are `clr`, `en`, `label`; outputs are `best`, `best_cnt`, `oor`.
- **`knn_vote` itself:** keeps the FSM, index counter, `keff` latch and output registers.
- **Integration:** `iob_knn` muxes `SEL` between software and `knn_vote` using `busy`.

## Test plan

1. **Reset:** assert `rst` for 2 cycles, then release. Require all outputs 0, `busy=0`, and no `done` for 20 idle cycles.
2. **Majority:** k=10 with labels [3,3,5,5,5,3,1,1,1,1]. Require `done` exactly at cycle 12, `class_o=1`, `votes_o=4`, `err=0`, and `sel_o` sequence 0..9 on cycles 1..10.
3. **Tie:** k=4 with labels [2,7,7,2]. Require `class_o=7`, `votes_o=2`, `done` at cycle 6.
4. **Edge counts:**
   - k=0: require `done` at cycle 2, `class_o=0`, `votes_o=0`, `sel_o` never leaves 0.
   - k=15 with HW_K=10: require clamping to 10 and `done` at cycle 12.
5. **Out-of-range:** k=3 with labels [12,4,12]. Require `class_o=4`, `votes_o=1`, `err=1`. The next vote with valid labels clears `err`.
6. **Abort and restart:**
   - Pulse `start` again at cycle 4 of a k=10 vote: require it to be ignored.
   - Assert `rst` at cycle 5: require IDLE and the previous `class_o` reset to 0 on the next cycle, with no `done`.
   - A fresh k=2 vote with labels [6,6]: require `class_o=6`, `votes_o=2`, `done` at cycle 4.
